// File: rtl/fetch_unit_r32i.sv
// fetch_unit_r32i: RV32I fetch stage owning the PC, one outstanding imem request, a skid word and redirects.
// Build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises sticky FetchFault and parks the fetcher.
module fetch_unit_r32i #(
    parameter int unsigned      dataW        = 32,
    parameter logic [dataW-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [dataW-1:0] NOP_INS      = 32'h0000_0013
) (
    input  logic             clock,
    input  logic             nReset,
    output logic             InsReq,
    output logic [dataW-1:0] InsAddr,
    input  logic             InsGnt,
    input  logic             InsRespValid,
    input  logic [dataW-1:0] InsRespData,
    output logic [dataW-1:0] InsOut,
    output logic [dataW-1:0] InsPC,
    output logic             InsOutValid,
    input  logic             DecodeReady,
    input  logic             AlwaysBranch,
    input  logic             TestBranch,
    input  logic             CondTrue,
    input  logic             AbsoluteBranch,
    input  logic [dataW-1:0] BranchPC,
    input  logic [dataW-1:0] BranchAddr,
    output logic             FetchFault
);
    localparam int unsigned insBytes = 4;

    typedef enum logic [1:0] {stIdle, stReq, stWait, stFull} fetchStateT;

    fetchStateT       state;
    logic [dataW-1:0] pc;
    logic [dataW-1:0] fetchPC;
    logic [dataW-1:0] skidIns;
    logic [dataW-1:0] skidPC;
    logic             drop;
    logic             faultQ;
    logic             redirect;
    logic             trapHit;
    logic [dataW-1:0] rawTarget;
    logic [dataW-1:0] target;

    // Redirect decode and target generation; the fetch address is always word aligned.
    always_comb begin
        redirect  = AlwaysBranch | (TestBranch & CondTrue);
        rawTarget = AbsoluteBranch ? {BranchAddr[dataW-1:1], 1'b0} : BranchPC + BranchAddr;
        target    = rawTarget & ~dataW'(3);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trapHit = redirect & rawTarget[1];
`else
    assign trapHit = 1'b0;
`endif

    assign InsAddr    = pc;
    assign FetchFault = faultQ;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state       <= stIdle;
            pc          <= RESET_VECTOR;
            fetchPC     <= '0;
            skidIns     <= NOP_INS;
            skidPC      <= '0;
            drop        <= 1'b0;
            faultQ      <= 1'b0;
            InsReq      <= 1'b0;
            InsOutValid <= 1'b0;
            InsOut      <= NOP_INS;
            InsPC       <= '0;
        end else if (trapHit || faultQ) begin
            // Misaligned redirect: park with no request and ignore everything until reset.
            faultQ      <= 1'b1;
            state       <= stIdle;
            drop        <= 1'b0;
            InsReq      <= 1'b0;
            InsOutValid <= 1'b0;
            InsOut      <= NOP_INS;
        end else if (redirect) begin
            pc          <= target;
            InsOutValid <= 1'b0;
            InsOut      <= NOP_INS;
            // A fetch still owed by memory must be swallowed before refetching.
            if ((state == stWait && !InsRespValid) || (state == stReq && InsGnt)) begin
                drop   <= 1'b1;
                state  <= stWait;
                InsReq <= 1'b0;
            end else begin
                drop   <= 1'b0;
                state  <= stReq;
                InsReq <= 1'b1;
            end
        end else begin
            if (InsOutValid && DecodeReady) begin
                InsOutValid <= 1'b0;
                InsOut      <= NOP_INS;
            end
            case (state)
                stIdle: begin
                    state  <= stReq;
                    InsReq <= 1'b1;
                end
                stReq: begin
                    if (InsGnt) begin
                        fetchPC <= pc;
                        pc      <= pc + dataW'(insBytes);
                        state   <= stWait;
                        InsReq  <= 1'b0;
                    end
                end
                stWait: begin
                    if (InsRespValid) begin
                        state  <= stReq;
                        InsReq <= 1'b1;
                        if (drop) begin
                            drop <= 1'b0;
                        end else if (!InsOutValid || DecodeReady) begin
                            InsOut      <= InsRespData;
                            InsPC       <= fetchPC;
                            InsOutValid <= 1'b1;
                        end else begin
                            skidIns <= InsRespData;
                            skidPC  <= fetchPC;
                            state   <= stFull;
                            InsReq  <= 1'b0;
                        end
                    end
                end
                stFull: begin
                    if (DecodeReady) begin
                        InsOut      <= skidIns;
                        InsPC       <= skidPC;
                        InsOutValid <= 1'b1;
                        state       <= stReq;
                        InsReq      <= 1'b1;
                    end
                end
                default: begin
                    state  <= stIdle;
                    InsReq <= 1'b0;
                end
            endcase
        end
    end
endmodule
